// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: occupancy states
// and the width of the flush statistics counter.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam int FLUSH_CNT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a small per-cycle increment (0..2).
// Sticks at all-ones once the sum would overflow.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [1:0]   inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W:0]   sum;

    always_comb begin
        sum     = {1'b0, count_q} + {{(W-1){1'b0}}, inc_i};
        count_d = sum[W] ? {W{1'b1}} : sum[W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline register (main + skid) with valid/ready handshakes,
// synchronous flush, freeze, and a saturating count of flushed entries.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 16,
    parameter int FLUSH_ZERO = 1
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [CTRL_W-1:0]      in_ctrl,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [CTRL_W-1:0]      out_ctrl,
    input  logic                   flush,
    input  logic                   hold,
    output logic [FLUSH_CNT_W-1:0] flush_cnt,
    output state_e                 state_dbg
);

    // Handshake: a transfer happens on an edge only when valid and ready are
    // both 1 in the preceding cycle; valid never depends on ready.
    state_e              state_q;
    logic [DATA_W-1:0]   main_data_q;
    logic [CTRL_W-1:0]   main_ctrl_q;
    logic [DATA_W-1:0]   skid_data_q;
    logic [CTRL_W-1:0]   skid_ctrl_q;
    logic                rst_done_q;
    logic                in_xfer;
    logic                out_xfer;
    logic [1:0]          flush_inc;

    assign in_ready  = (state_q != FULL) & ~hold & rst_done_q;
    assign out_valid = (state_q != EMPTY) & ~hold;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign state_dbg = state_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        flush_inc = 2'd0;
        if (flush) begin
            if (state_q == ONE)  flush_inc = 2'd1;
            if (state_q == FULL) flush_inc = 2'd2;
        end
    end

    // hold needs no branch: it forces both handshakes low, so nothing loads.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            rst_done_q  <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            if (flush) begin
                state_q <= EMPTY;
                if (FLUSH_ZERO != 0) begin
                    main_data_q <= '0;
                    main_ctrl_q <= '0;
                    skid_data_q <= '0;
                    skid_ctrl_q <= '0;
                end
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (in_xfer) begin
                            main_data_q <= in_data;
                            main_ctrl_q <= in_ctrl;
                            state_q     <= ONE;
                        end
                    end
                    ONE: begin
                        if (in_xfer && out_xfer) begin
                            main_data_q <= in_data;
                            main_ctrl_q <= in_ctrl;
                        end else if (in_xfer) begin
                            skid_data_q <= in_data;
                            skid_ctrl_q <= in_ctrl;
                            state_q     <= FULL;
                        end else if (out_xfer) begin
                            state_q <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (out_xfer) begin
                            main_data_q <= skid_data_q;
                            main_ctrl_q <= skid_ctrl_q;
                            state_q     <= ONE;
                        end
                    end
                    default: state_q <= EMPTY;
                endcase
            end
        end
    end

    sat_counter #(
        .W(FLUSH_CNT_W)
    ) u_flush_cnt (
        .clk_i  (Clk),
        .rst_ni (Rst_n),
        .inc_i  (flush_inc),
        .count_o(flush_cnt)
    );

endmodule
